instr_loader: RTL
=================

// Module: instr_loader
// PURPOSE
// - Upstream of the MIPS datapath. Accepts a program as a stream of 32-bit words
//   over a valid/ready handshake and writes them into instruction memory at byte
//   addresses 0, 4, 8, ...
// - Holds the PC in reset while loading, then releases the core: PC write and
//   instruction read are enabled and the initializing flag is cleared.
// - Replaces bench-side program loading with synthesizable sequencing.
// PARAMETERS
// - MAX_WORDS  256  capacity of instruction memory in words; longer programs are rejected
// - LEN_W      16   width of length and count fields
// PORTS
// - clk           in   1      rising-edge clock
// - reset         in   1      asynchronous, active-high
// - start         in   1      1-cycle pulse: begin (re)load of progLength words
// - progLength    in   LEN_W  number of words to load; valid range 1..MAX_WORDS
// - wordIn        in   32     program word
// - wordValid     in   1      wordIn is valid
// - wordReady     out  1      loader accepts a word this cycle
// - instrAddr     out  32     instruction memory address (byte address)
// - instrIn       out  32     instruction memory write data
// - instrWrite    out  1      instruction memory write enable
// - instrRead     out  1      instruction memory read enable (core running)
// - pcReset       out  1      hold PC at 0
// - pcWrite       out  1      PC update enable
// - initializing  out  1      high until core is released; steers instruction-address mux
// - done          out  1      program loaded, core running
// - error         out  1      bad length, or checksum mismatch (see CONFIGURATION)
// - wordCount     out  LEN_W  words written so far
// BEHAVIOUR
// - States: IDLE, LOAD, FLUSH, RUN, ERR. All outputs are registered.
// - Reset (async): state=IDLE, wordCount=0, instrAddr=0, instrIn=0, instrWrite=0,
//   instrRead=0, pcReset=1, pcWrite=0, initializing=1, done=0, error=0, wordReady=0.
// - IDLE: wait for start.
//   - progLength in 1..MAX_WORDS: latch length, clear count -> LOAD.
//   - Otherwise (0 or >MAX_WORDS) -> ERR.
// - LOAD: wordReady=1. Transfer occurs when wordValid && wordReady (one word per cycle max).
//   - On a transfer: next cycle instrIn=wordIn, instrAddr=wordCount*4 (pre-increment),
//     instrWrite=1; wordCount increments.
//   - Cycles with no transfer: instrWrite=0.
//   - Write latency is 1 cycle after the handshake.
//   - When the last word transfers: wordReady drops the next cycle -> FLUSH.
// - FLUSH: one cycle. The final write is presented here; instrWrite=0 after.
// - RUN: pcReset=0, pcWrite=1, instrRead=1, initializing=0, done=1, wordReady=0.
//   - The outputs above all take these values on the same clock edge, so the PC
//     starts from 0 the cycle after release.
// - ERR: error=1, pcReset=1, done=0. Remains here until reset or a start with a valid length.
// - start in LOAD or FLUSH is ignored.
// - start in RUN with a valid length: back to LOAD. pcReset=1, pcWrite=0, instrRead=0,
//   initializing=1, done=0 on the next edge; count cleared. Invalid length -> ERR.
// - wordValid outside LOAD: ignored; no write.
// - Address arithmetic: instrAddr = {wordCount, 2'b00}, zero-extended to 32 bits.
//   wordCount never exceeds progLength, so there is no wrap.
// - Reset mid-LOAD: abort immediately to reset values. Already-written memory
//   contents are left as-is.
// CONFIGURATION
// - INSTR_LOADER_CHECKSUM_EN defined:
//   - Adds ports expectedSum (in, 32) and checksum (out, 32).
//   - checksum = mod-2^32 sum of accepted words; cleared on start and on reset.
//   - FLUSH goes to RUN if checksum == expectedSum (sampled in FLUSH), else ERR.
// - Undefined: no extra ports; FLUSH always goes to RUN.
// STRUCTURE
// - Shared package mips_pkg holds: loader state encoding, WORD_BYTES=4, INSTR_WORD_W=32.
// - Single module; no sub-module. The count/address register is an inline counter.
// TESTING
// - Reset then idle: pcReset=1, initializing=1, done=0, instrWrite=0, wordReady=0
//   for 10 cycles.
// - start, progLength=2; words 0x20100002 and 0x22100003 back-to-back:
//   - writes (addr 0, 0x20100002) then (addr 4, 0x22100003) on consecutive cycles.
//   - done=1, pcReset=0, pcWrite=1 two cycles after the last handshake.
// - Same load with wordValid gapped 3 cycles between words: no spurious writes;
//   addresses 0 and 4; wordCount=2 at done.
// - start with progLength=0, then progLength=MAX_WORDS+1: error=1 in both cases,
//   no writes, pcReset stays 1.
// - Reset asserted after 1 of 3 words: all outputs at reset values within the same
//   cycle. A new start with progLength=3 then loads addresses 0, 4, 8.
// - CHECKSUM_EN: words 1, 2, 3 with expectedSum=6 -> RUN; with expectedSum=7 -> ERR, done=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
// Holds the instruction-loader state encoding and the instruction word
// geometry used by the loader and the datapath.
package mips_pkg;

  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned INSTR_WORD_W = 32;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_FLUSH,
    LD_RUN,
    LD_ERR
  } loader_state_t;

endpackage : mips_pkg

// File: rtl/instr_loader.sv
// instr_loader: streams a program into instruction memory over a valid/ready
// handshake, holding the MIPS core in reset until the load completes.
//
// Words are written at byte addresses 0, 4, 8, ... one cycle after their
// handshake. After the last word a single FLUSH cycle presents the final write,
// then the core is released (pcReset low, pcWrite/instrRead/done high,
// initializing low) on one clock edge.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start, progLength    1-cycle load request and its length (1..MAX_WORDS)
//   wordIn, wordValid    program word stream; wordReady is the accept signal
//   instrAddr, instrIn,  instruction memory address/data/write enable
//   instrWrite
//   instrRead            instruction memory read enable (core running)
//   pcReset, pcWrite     PC hold / update enable
//   initializing         steers the instruction-address mux while loading
//   done, error          core running / bad length or checksum mismatch
//   wordCount            words written so far
//
// Build option INSTR_LOADER_CHECKSUM_EN: adds expectedSum (in) and checksum
// (out, mod-2^32 sum of accepted words); FLUSH then enters RUN only when the
// sums agree, otherwise ERR.
module instr_loader
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned LEN_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        progLength,
  input  logic [INSTR_WORD_W-1:0] wordIn,
  input  logic                    wordValid,
`ifdef INSTR_LOADER_CHECKSUM_EN
  input  logic [INSTR_WORD_W-1:0] expectedSum,
  output logic [INSTR_WORD_W-1:0] checksum,
`endif
  output logic                    wordReady,
  output logic [31:0]             instrAddr,
  output logic [INSTR_WORD_W-1:0] instrIn,
  output logic                    instrWrite,
  output logic                    instrRead,
  output logic                    pcReset,
  output logic                    pcWrite,
  output logic                    initializing,
  output logic                    done,
  output logic                    error,
  output logic [LEN_W-1:0]        wordCount
);

  loader_state_t state_q, state_d;

  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic [31:0]             addr_d;
  logic [INSTR_WORD_W-1:0] data_d;
  logic                    write_d;
  logic                    len_ok;
  logic                    xfer;
  logic                    last_word;
  logic                    run_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [INSTR_WORD_W-1:0] sum_q, sum_d;
`endif

  assign len_ok    = (progLength != '0) && (32'(progLength) <= MAX_WORDS);
  assign xfer      = (state_q == LD_LOAD) && wordValid && wordReady;
  assign last_word = (count_q + LEN_W'(1)) == len_q;
  assign wordCount = count_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign checksum  = sum_q;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = instrAddr;
    data_d  = instrIn;
    write_d = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    unique case (state_q)
      LD_IDLE, LD_RUN, LD_ERR: begin
        if (start) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d = '0;
`endif
          if (len_ok) begin
            state_d = LD_LOAD;
            len_d   = progLength;
            count_d = '0;
          end else begin
            state_d = LD_ERR;
          end
        end
      end
      LD_LOAD: begin
        if (xfer) begin
          // Address uses the pre-increment count, i.e. {wordCount, 2'b00}.
          addr_d  = 32'(count_q) * 32'(WORD_BYTES);
          data_d  = wordIn;
          write_d = 1'b1;
          count_d = count_q + LEN_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d   = sum_q + wordIn;
`endif
          if (last_word) begin
            state_d = LD_FLUSH;
          end
        end
      end
      LD_FLUSH: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        state_d = (sum_q == expectedSum) ? LD_RUN : LD_ERR;
`else
        state_d = LD_RUN;
`endif
      end
      default: state_d = LD_IDLE;
    endcase

    run_d = (state_d == LD_RUN);
  end

  // Status outputs are registered copies of the next state's decode, so every
  // release/hold signal changes on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LD_IDLE;
      len_q        <= '0;
      count_q      <= '0;
      instrAddr    <= '0;
      instrIn      <= '0;
      instrWrite   <= 1'b0;
      instrRead    <= 1'b0;
      pcReset      <= 1'b1;
      pcWrite      <= 1'b0;
      initializing <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      wordReady    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      count_q      <= count_d;
      instrAddr    <= addr_d;
      instrIn      <= data_d;
      instrWrite   <= write_d;
      instrRead    <= run_d;
      pcReset      <= ~run_d;
      pcWrite      <= run_d;
      initializing <= ~run_d;
      done         <= run_d;
      error        <= (state_d == LD_ERR);
      wordReady    <= (state_d == LD_LOAD);
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

endmodule : instr_loader
